// File: rtl/parallel_to_serial.sv
// Parallel-in, serial-out unloader: captures one packed word of `size` elements and streams them out one per beat.
// Optional build macro SERIALIZER_MSB_FIRST_EN emits the highest-index element first.
module parallel_to_serial #(
    parameter int dataWidth = 16,
    parameter int size      = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ce,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [dataWidth*size-1:0]   data_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [dataWidth-1:0]        data_out,
    output logic                        out_last,
    output logic                        busy
);

    // state | meaning
    // IDLE  | no word held; ready to accept a new word
    // SHIFT | word held; data_out presents element for beat r_count
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int CW = ($clog2(size) < 1) ? 1 : $clog2(size);
    localparam logic [CW-1:0] LAST_IDX = CW'(size - 1);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [CW-1:0]               r_count;
    logic [CW-1:0]               w_count_inc;
    logic [dataWidth*size-1:0]   r_hold;
    logic [dataWidth-1:0]        r_data_out;
    logic                        w_shift;
    logic                        w_last_beat;
    logic                        w_in_xfer;
    logic                        w_out_xfer;

    // Maps a beat number to the element it carries in this build's emission order.
    function automatic logic [dataWidth-1:0] f_pick(
        input logic [dataWidth*size-1:0] word,
        input logic [CW-1:0]             beat
    );
        int pos;
`ifdef SERIALIZER_MSB_FIRST_EN
        pos = size - 1 - int'(beat);
`else
        pos = int'(beat);
`endif
        return word[pos*dataWidth +: dataWidth];
    endfunction

    assign w_shift     = (r_state == SHIFT);
    assign w_last_beat = w_shift && (r_count == LAST_IDX);
    assign w_count_inc = r_count + CW'(1);

    // out_ready feeds in_ready combinationally so a new word loads on the final beat with no bubble.
    assign in_ready   = ce & (~w_shift | (w_last_beat & out_ready));
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = w_shift & out_ready & ce;

    assign out_valid = w_shift;
    assign out_last  = w_last_beat;
    assign busy      = w_shift;
    assign data_out  = r_data_out;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else if (ce) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_in_xfer) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_out_xfer && w_last_beat && !w_in_xfer) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // data_out is kept as its own register, loaded with the element the next beat will present.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count    <= '0;
            r_hold     <= '0;
            r_data_out <= '0;
        end else if (w_in_xfer) begin
            r_hold     <= data_in;
            r_count    <= '0;
            r_data_out <= f_pick(data_in, {CW{1'b0}});
        end else if (w_out_xfer) begin
            if (w_last_beat) begin
                r_count <= '0;
            end else begin
                r_count    <= w_count_inc;
                r_data_out <= f_pick(r_hold, w_count_inc);
            end
        end
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Scoreboard bench for parallel_to_serial: driver pushes expected beats on word acceptance, monitor pops on output transfers.
module tb_parallel_to_serial;

    localparam int DW   = 16;
    localparam int SIZE = 3;
    localparam int W    = DW * SIZE;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  data_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] data_out;
    logic          out_last;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DW:0] exp_q[$];
    bit          rand_mode = 1'b0;

    logic          prev_valid   = 1'b0;
    logic          prev_xfer    = 1'b0;
    logic          prev_in_xfer = 1'b0;
    logic          prev_rst_hi  = 1'b0;
    logic [DW-1:0] prev_data    = '0;
    logic          prev_last    = 1'b0;

    parallel_to_serial #(.dataWidth(DW), .size(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: a word becomes SIZE beats in emission order, last flag on the final one.
    task automatic push_word(input logic [W-1:0] w);
        for (int k = 0; k < SIZE; k++) begin
            int idx;
`ifdef SERIALIZER_MSB_FIRST_EN
            idx = SIZE - 1 - k;
`else
            idx = k;
`endif
            exp_q.push_back({(k == SIZE - 1) ? 1'b1 : 1'b0, w[idx*DW +: DW]});
        end
    endtask

    // Monitor: samples on the falling edge, between driver updates and the next active edge.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (rst) begin
            chk("busy_eq_valid", busy, out_valid);
            chk("in_ready", in_ready, ce & (~out_valid | (out_last & out_ready)));
            if (prev_in_xfer) chk("latency_valid", out_valid, 1'b1);
            if (prev_rst_hi && prev_valid && !prev_xfer) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", data_out, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            if (out_valid && out_ready && ce) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", data_out, 64'hDEAD_BEEF_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out", data_out, e[DW-1:0]);
                    chk("out_last", out_last, e[DW]);
                end
            end
        end
        prev_rst_hi  = rst;
        prev_valid   = out_valid;
        prev_xfer    = out_valid & out_ready & ce;
        prev_in_xfer = in_valid & in_ready & ce & rst;
        prev_data    = data_out;
        prev_last    = out_last;
    end

    always @(posedge clk) begin
        #1;
        if (rand_mode) begin
            out_ready = ($urandom_range(0, 9) < 7);
            ce        = ($urandom_range(0, 9) < 9);
        end
    end

    // Holds the word until accepted, registers its expected beats, returns just after the capturing edge.
    task automatic send_word(input logic [W-1:0] w);
        bit done = 1'b0;
        in_valid = 1'b1;
        data_in  = w;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_valid && in_ready && ce && rst) begin
                push_word(w);
                done = 1'b1;
            end
        end
        if (!done) chk("send_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done = 1'b0;
        in_valid = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) chk("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        chk({name, "_out_valid"}, out_valid, 1'b0);
        chk({name, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] w;
        rst       = 1'b0;
        ce        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_data_out", data_out, 0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // basic
        send_word(48'h0003_0002_0001);
        drain();
        idle_check("basic");

        // backpressure on the second beat
        send_word(48'h0003_0002_0001);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();

        // back-to-back with in_valid held
        send_word(48'h0003_0002_0001);
        send_word(48'h0006_0005_0004);
        drain();
        idle_check("b2b");

        // ce gating mid-word
        send_word(48'h0009_0008_0007);
        in_valid = 1'b0;
        ce = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        ce = 1'b1;
        drain();

        // reset mid-word
        send_word(48'h0003_0002_0001);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_data_out", data_out, 0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_out_last", out_last, 1'b0);
        rst = 1'b1;
        send_word(48'h00CC_00BB_00AA);
        drain();

        // randomized words, ready and ce
        rand_mode = 1'b1;
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < SIZE; k++) w[k*DW +: DW] = DW'($urandom());
            send_word(w);
            if ($urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 4)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        drain();
        rand_mode = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        ce        = 1'b1;
        idle_check("final");
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
